cache_fill_arbiter: RTL and testbench

Multi-cycle main-memory controller for the cached 16-bit pipelined CPU. It arbitrates between I-cache miss fills and D-cache miss fills or write-through stores. It sequences 8-word block fills against the single shared pipelined main memory and steers returned words into the requesting cache. It sits between both caches and the 4-cycle main memory, and is the only block that drives memory address and control.

---
 rtl/cache_fill_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Main-memory fill/store sequencer shared by the I- and D-caches.
// Define ARB_ROUND_ROBIN_EN for round-robin I/D arbitration; the default build gives D fixed priority.
module cache_fill_arbiter #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned MEM_LAT         = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ic_req_i,
   input  logic [15:0]                        ic_addr_i,
   input  logic                               dc_req_i,
   input  logic                               dc_wr_i,
   input  logic [15:0]                        dc_addr_i,
   input  logic [15:0]                        dc_wdata_i,
   output logic                               mem_enable_o,
   output logic                               mem_wr_o,
   output logic [15:0]                        mem_addr_o,
   output logic [15:0]                        mem_wdata_o,
   input  logic                               mem_data_valid_i,
   input  logic [15:0]                        mem_rdata_i,
   output logic [15:0]                        fill_data_o,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_o,
   output logic                               ic_fill_we_o,
   output logic                               dc_fill_we_o,
   output logic                               ic_done_o,
   output logic                               dc_done_o,
   output logic                               busy_o
);

   localparam int unsigned WordW = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned CntW  = WordW + 1;
   localparam logic [15:0]     BlockMask = ~16'(2 * WORDS_PER_BLOCK - 1);
   localparam logic [CntW-1:0] NumWords  = CntW'(WORDS_PER_BLOCK);
   localparam logic [CntW-1:0] LastWord  = CntW'(WORDS_PER_BLOCK - 1);

   if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_words
      $error("WORDS_PER_BLOCK must be a power of 2 and at least 2");
   end
   if (MEM_LAT == 0) begin : g_bad_lat
      $error("MEM_LAT must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0] recv_cnt_q, recv_cnt_d;
   logic            req_ic_q, req_ic_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;

   logic dc_any;
   logic grant_d;
   logic grant_i;

   assign dc_any = dc_req_i | dc_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_d_next_q;

   assign grant_d = dc_any & (~ic_req_i | rr_d_next_q);

   // Pointer names the side that wins the next I/D conflict.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_d_next_q <= 1'b1;
      end else if (state_q == StIdle && (grant_d || grant_i)) begin
         rr_d_next_q <= grant_i;
      end
   end
`else
   assign grant_d = dc_any;
`endif

   assign grant_i = ic_req_i & ~grant_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         req_ic_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         req_ic_q    <= req_ic_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      issue_cnt_d  = issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      req_ic_d     = req_ic_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_enable_o = 1'b0;
      mem_wr_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      fill_data_o  = '0;
      fill_word_o  = '0;
      ic_fill_we_o = 1'b0;
      dc_fill_we_o = 1'b0;
      ic_done_o    = 1'b0;
      dc_done_o    = 1'b0;

      unique case (state_q)
         StIdle: begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            if (grant_d) begin
               req_ic_d = 1'b0;
               wdata_d  = dc_wdata_i;
               // A pending store beats a pending fill on the D side.
               if (dc_wr_i) begin
                  addr_d  = dc_addr_i;
                  state_d = StWrite;
               end else begin
                  addr_d  = dc_addr_i & BlockMask;
                  state_d = StFill;
               end
            end else if (grant_i) begin
               req_ic_d = 1'b1;
               addr_d   = ic_addr_i & BlockMask;
               state_d  = StFill;
            end
         end
         StFill: begin
            if (issue_cnt_q < NumWords) begin
               mem_enable_o = 1'b1;
               mem_addr_o   = addr_q + {{(15 - WordW){1'b0}}, issue_cnt_q[WordW-1:0], 1'b0};
               issue_cnt_d  = issue_cnt_q + 1'b1;
            end
            fill_data_o  = mem_rdata_i;
            fill_word_o  = recv_cnt_q[WordW-1:0];
            ic_fill_we_o = mem_data_valid_i & req_ic_q;
            dc_fill_we_o = mem_data_valid_i & ~req_ic_q;
            if (mem_data_valid_i) begin
               recv_cnt_d = recv_cnt_q + 1'b1;
               if (recv_cnt_q == LastWord) begin
                  state_d = StDone;
               end
            end
         end
         StWrite: begin
            mem_enable_o = 1'b1;
            mem_wr_o     = 1'b1;
            mem_addr_o   = addr_q;
            mem_wdata_o  = wdata_q;
            state_d      = StDone;
         end
         StDone: begin
            ic_done_o = req_ic_q;
            dc_done_o = ~req_ic_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: bench-side memory model plus scoreboard queues for
// memory accesses, cache fill writes and done pulses, each stamped with its expected cycle.
module tb_cache_fill_arbiter;

   localparam int unsigned W   = 8;
   localparam int unsigned LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ic_req = 1'b0;
   logic [15:0] ic_addr = '0;
   logic        dc_req = 1'b0;
   logic        dc_wr = 1'b0;
   logic [15:0] dc_addr = '0;
   logic [15:0] dc_wdata = '0;
   logic        mem_enable, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_data_valid;
   logic [15:0] mem_rdata;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        ic_fill_we, dc_fill_we, ic_done, dc_done, busy;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned k;
   logic        spur = 1'b0;

   typedef struct packed {
      logic [15:0] cyc;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } mem_t;
   typedef struct packed {
      logic [15:0] cyc;
      logic        ic_we;
      logic        dc_we;
      logic [2:0]  word;
      logic [15:0] data;
   } fill_t;
   typedef struct packed {
      logic [15:0] cyc;
      logic        ic;
      logic        dc;
   } done_t;

   mem_t  mem_q[$];
   fill_t fill_q[$];
   done_t done_q[$];
   mem_t  mo, me;
   fill_t fo, fe;
   done_t dob, de;

   logic [57:0] outs;
   assign outs = {mem_enable, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                  ic_fill_we, dc_fill_we, ic_done, dc_done, busy};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cache_fill_arbiter #(
      .WORDS_PER_BLOCK(W),
      .MEM_LAT        (LAT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ic_req_i        (ic_req),
      .ic_addr_i       (ic_addr),
      .dc_req_i        (dc_req),
      .dc_wr_i         (dc_wr),
      .dc_addr_i       (dc_addr),
      .dc_wdata_i      (dc_wdata),
      .mem_enable_o    (mem_enable),
      .mem_wr_o        (mem_wr),
      .mem_addr_o      (mem_addr),
      .mem_wdata_o     (mem_wdata),
      .mem_data_valid_i(mem_data_valid),
      .mem_rdata_i     (mem_rdata),
      .fill_data_o     (fill_data),
      .fill_word_o     (fill_word),
      .ic_fill_we_o    (ic_fill_we),
      .dc_fill_we_o    (dc_fill_we),
      .ic_done_o       (ic_done),
      .dc_done_o       (dc_done),
      .busy_o          (busy)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[15:8], 8'hA0 + {5'b0, a[3:1]}};
   endfunction

   // Pipelined memory: a read issued in cycle c returns data in cycle c+LAT; not reset.
   logic [LAT-1:0] pv = '0;
   logic [15:0]    pd [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_enable && !mem_wr};
      pd[0] <= mem_word(mem_addr);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign mem_data_valid = pv[LAT-1] | spur;
   assign mem_rdata      = pd[LAT-1];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_some(input string tag, input int n, input logic [63:0] obs);
      checks++;
      assert (n != 0)
      else begin
         errors++;
         $error("FAIL %s observed %h expected none", tag, obs);
      end
   endtask

   always @(negedge clk) begin
      if (mem_enable) begin
         mo = '{cyc: 16'(cyc), wr: mem_wr, addr: mem_addr, wdata: mem_wr ? mem_wdata : 16'h0};
         check_some("mem_unexpected", mem_q.size(), 64'(mo));
         if (mem_q.size() != 0) begin
            me = mem_q.pop_front();
            check_eq("mem_access", 64'(mo), 64'(me));
         end
      end
   end

   always @(negedge clk) begin
      if (ic_fill_we || dc_fill_we) begin
         fo = '{cyc: 16'(cyc), ic_we: ic_fill_we, dc_we: dc_fill_we, word: fill_word,
                data: fill_data};
         check_some("fill_unexpected", fill_q.size(), 64'(fo));
         if (fill_q.size() != 0) begin
            fe = fill_q.pop_front();
            check_eq("fill_write", 64'(fo), 64'(fe));
         end
      end
   end

   always @(negedge clk) begin
      if (ic_done || dc_done) begin
         dob = '{cyc: 16'(cyc), ic: ic_done, dc: dc_done};
         check_some("done_unexpected", done_q.size(), 64'(dob));
         if (done_q.size() != 0) begin
            de = done_q.pop_front();
            check_eq("done_pulse", 64'(dob), 64'(de));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push_fill(input logic ic, input int unsigned kk, input logic [15:0] addr);
      logic [15:0] base;
      base = addr & 16'hFFF0;
      for (int i = 0; i < W; i++) begin
         mem_q.push_back('{cyc: 16'(kk + 1 + i), wr: 1'b0, addr: base + 16'(2 * i),
                           wdata: 16'h0});
         fill_q.push_back('{cyc: 16'(kk + 1 + LAT + i), ic_we: ic, dc_we: !ic, word: 3'(i),
                            data: mem_word(base + 16'(2 * i))});
      end
      done_q.push_back('{cyc: 16'(kk + W + LAT + 1), ic: ic, dc: !ic});
   endtask

   task automatic push_store(input int unsigned kk, input logic [15:0] a, input logic [15:0] d);
      mem_q.push_back('{cyc: 16'(kk + 1), wr: 1'b1, addr: a, wdata: d});
      done_q.push_back('{cyc: 16'(kk + 2), ic: 1'b0, dc: 1'b1});
   endtask

   task automatic drain(input string tag);
      check_eq(tag, 64'(mem_q.size() + fill_q.size() + done_q.size()), 64'd0);
   endtask

   initial begin
      step(3);
      check_eq("reset_outs", 64'(outs), 64'd0);
      rst_n = 1'b1;
      step(2);
      check_eq("idle_outs", 64'(outs), 64'd0);

      // I-cache miss at 0x1236.
      k = cyc;
      ic_addr = 16'h1236;
      ic_req  = 1'b1;
      push_fill(1'b1, k, 16'h1236);
      check_eq("i_busy_k", 64'(busy), 64'd0);
      step(1);
      check_eq("i_busy_k1", 64'(busy), 64'd1);
      step(12);
      ic_req = 1'b0;
      step(2);
      check_eq("i_idle_after", 64'(busy), 64'd0);
      drain("i_drain");

      // Write-through store.
      k = cyc;
      dc_addr  = 16'h0040;
      dc_wdata = 16'hBEEF;
      dc_wr    = 1'b1;
      push_store(k, 16'h0040, 16'hBEEF);
      step(1);
      check_eq("st_busy", 64'(busy), 64'd1);
      step(1);
      dc_wr = 1'b0;
      step(2);
      drain("st_drain");

      // Simultaneous I and D fills held across four grants, from a fresh pointer.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
      k = cyc;
      ic_addr = 16'h2000;
      dc_addr = 16'h3010;
      ic_req  = 1'b1;
      dc_req  = 1'b1;
      for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
         push_fill(g[0], k + 14 * g, g[0] ? 16'h2000 : 16'h3010);
`else
         push_fill(1'b0, k + 14 * g, 16'h3010);
`endif
      end
      step(55);
      ic_req = 1'b0;
      dc_req = 1'b0;
      step(2);
      drain("arb_drain");

      // Store and fill both pending on the D side: store first, fill afterwards.
      k = cyc;
      dc_addr  = 16'h0052;
      dc_wdata = 16'h1234;
      dc_wr    = 1'b1;
      dc_req   = 1'b1;
      push_store(k, 16'h0052, 16'h1234);
      push_fill(1'b0, k + 3, 16'h0052);
      step(2);
      dc_wr = 1'b0;
      step(14);
      dc_req = 1'b0;
      step(2);
      drain("wr_rd_drain");

      // Reset asserted in cycle k+5 of an I fill.
      k = cyc;
      ic_addr = 16'h4444;
      ic_req  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mem_q.push_back('{cyc: 16'(k + 1 + i), wr: 1'b0, addr: 16'h4440 + 16'(2 * i),
                           wdata: 16'h0});
      end
      fill_q.push_back('{cyc: 16'(k + 5), ic_we: 1'b1, dc_we: 1'b0, word: 3'd0,
                         data: mem_word(16'h4440)});
      step(5);
      rst_n  = 1'b0;
      ic_req = 1'b0;
      step(1);
      check_eq("rst_mid_outs", 64'(outs), 64'd0);
      rst_n = 1'b1;
      step(6);
      check_eq("rst_mid_idle", 64'(busy), 64'd0);
      drain("rst_drain");

      // Spurious read-valid while idle.
      spur = 1'b1;
      #1;
      check_eq("spur_we", 64'({ic_fill_we, dc_fill_we}), 64'd0);
      step(1);
      spur = 1'b0;
      check_eq("spur_busy", 64'(busy), 64'd0);
      step(2);
      check_eq("spur_outs", 64'(outs), 64'd0);
      drain("final_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
